// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: types shared by the fetch stage and its lane compactor.
//   fetch_entry_t : one instruction plus the address it was fetched from.
//   fetch_state_e : fetch FSM encodings (request, wait for response, hold block).
//   block_align   : clears the in-block byte offset of an address.
package fetch_stage_pkg;

  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH_STATE_REQ  = 2'd0,
    FETCH_STATE_WAIT = 2'd1,
    FETCH_STATE_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] block_align(input logic [31:0] addr,
                                              input int unsigned width);
    logic [31:0] mask;
    mask = 32'(width * INST_BYTES - 1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/fetch_lane_compactor.sv
// fetch_lane_compactor: shifts a fetched block down so that the instruction at
// the fetch pc lands in output lane 0, and builds a contiguous valid mask.
//   pc         : fetch pc, its in-block word offset selects the first lane
//   block_addr : block-aligned address the block was fetched from
//   block      : fetched instructions, lane 0 lowest
//   active     : qualifies the valid mask (block is present)
//   entries    : compacted {pc, inst} entries
//   valid      : ones from bit 0, one per compacted entry
module fetch_lane_compactor
  import fetch_stage_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2
) (
  input  logic [31:0]                   pc,
  input  logic [31:0]                   block_addr,
  input  logic [FETCH_WIDTH-1:0][31:0]  block,
  input  logic                          active,
  output fetch_entry_t [FETCH_WIDTH-1:0] entries,
  output logic [FETCH_WIDTH-1:0]        valid
);

  localparam int unsigned IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  logic [31:0] k;
  logic [31:0] src;

  always_comb begin
    k   = (pc >> 2) & 32'(FETCH_WIDTH - 1);
    src = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      src           = k + i;
      entries[i]    = '0;
      valid[i]      = 1'b0;
      if (src < FETCH_WIDTH) begin
        entries[i].pc   = block_addr + (src << 2);
        entries[i].inst = block[src[IDX_W-1:0]];
        valid[i]        = active;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end. Requests one aligned block at a
// time from the instruction bus, holds the response, and pushes the
// instructions from the fetch pc onward into the fetch FIFO as one unit.
// A redirect flushes the FIFO and restarts fetch at the target; a response
// already in flight when the redirect happens is discarded on arrival.
//   clk, rst               : clock, asynchronous active-high reset
//   bus_req/bus_addr       : block request and its aligned address
//   bus_ready              : request accepted
//   bus_rvalid/bus_rdata   : response strobe and block data (lane 0 lowest)
//   fifo_data_in(_valid)   : compacted entries and contiguous valid mask
//   fifo_push              : push strobe (all entries or none)
//   fifo_data_in_enable    : free-slot mask from the FIFO
//   fifo_full, fifo_flush  : FIFO full flag, flush strobe on redirect
//   jump_valid/jump_pc     : redirect request and target
//   fetch_stall_cnt        : cycles spent holding a block that could not push
// Build option: define FETCH_STALL_COUNTER_EN to implement the stall counter;
// otherwise fetch_stall_cnt is tied to zero.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h8000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           bus_req,
  output logic [31:0]                    bus_addr,
  input  logic                           bus_ready,
  input  logic                           bus_rvalid,
  input  logic [32*FETCH_WIDTH-1:0]      bus_rdata,
  output fetch_entry_t [FETCH_WIDTH-1:0] fifo_data_in,
  output logic [FETCH_WIDTH-1:0]         fifo_data_in_valid,
  output logic                           fifo_push,
  input  logic [FETCH_WIDTH-1:0]         fifo_data_in_enable,
  input  logic                           fifo_full,
  output logic                           fifo_flush,
  input  logic                           jump_valid,
  input  logic [31:0]                    jump_pc,
  output logic [31:0]                    fetch_stall_cnt
);

  localparam int unsigned CNT_W       = $clog2(FETCH_WIDTH + 1);
  localparam logic [31:0] BLOCK_BYTES = 32'(FETCH_WIDTH * INST_BYTES);

  fetch_state_e                 state_q, state_d;
  logic [31:0]                  pc_q, pc_d;
  logic                         drop_q, drop_d;
  logic [31:0]                  hold_addr_q, hold_addr_d;
  logic [FETCH_WIDTH-1:0][31:0] hold_data_q, hold_data_d;

  logic [31:0]      aligned_pc;
  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] valid_cnt;
  logic             in_hold;

  assign aligned_pc = block_align(pc_q, FETCH_WIDTH);
  assign in_hold    = (state_q == FETCH_STATE_HOLD) && !rst;

  fetch_lane_compactor #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_compactor (
    .pc         (pc_q),
    .block_addr (hold_addr_q),
    .block      (hold_data_q),
    .active     (in_hold),
    .entries    (fifo_data_in),
    .valid      (fifo_data_in_valid)
  );

  always_comb begin
    free_cnt  = '0;
    valid_cnt = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      free_cnt  = free_cnt + CNT_W'(fifo_data_in_enable[i]);
      valid_cnt = valid_cnt + CNT_W'(fifo_data_in_valid[i]);
    end
  end

  // No new request while a discarded response is still on its way back.
  assign bus_req    = !rst && (state_q == FETCH_STATE_REQ) && !drop_q;
  assign bus_addr   = aligned_pc;
  assign fifo_flush = !rst && jump_valid;
  assign fifo_push  = in_hold && !fifo_full && (free_cnt >= valid_cnt) && !jump_valid;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    if (jump_valid) begin
      state_d = FETCH_STATE_REQ;
      pc_d    = jump_pc;
      // A response arriving this very cycle is consumed here; otherwise any
      // accepted-but-unanswered request must be drained later.
      drop_d  = ((state_q == FETCH_STATE_WAIT) && !bus_rvalid) ||
                (bus_req && bus_ready) ||
                (drop_q && !bus_rvalid);
    end else begin
      unique case (state_q)
        FETCH_STATE_REQ: begin
          if (drop_q) begin
            if (bus_rvalid) drop_d = 1'b0;
          end else if (bus_ready) begin
            state_d = FETCH_STATE_WAIT;
          end
        end
        FETCH_STATE_WAIT: begin
          if (bus_rvalid) begin
            hold_data_d = bus_rdata;
            hold_addr_d = aligned_pc;
            state_d     = FETCH_STATE_HOLD;
          end
        end
        FETCH_STATE_HOLD: begin
          if (fifo_push) begin
            pc_d    = aligned_pc + BLOCK_BYTES;
            state_d = FETCH_STATE_REQ;
          end
        end
        default: state_d = FETCH_STATE_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH_STATE_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

`ifdef FETCH_STALL_COUNTER_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (in_hold && !fifo_push && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_stall_cnt = stall_cnt_q;
`else
  assign fetch_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a bus responder, a
// transaction-level fetch model checked every cycle, and literal checkpoints.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int unsigned FW       = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef FETCH_STALL_COUNTER_EN
  localparam logic [31:0] EXP_STALL = 32'd5;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  bus_req;
  logic [31:0]           bus_addr;
  logic                  bus_ready;
  logic                  bus_rvalid;
  logic [32*FW-1:0]      bus_rdata;
  fetch_entry_t [FW-1:0] fifo_data_in;
  logic [FW-1:0]         fifo_data_in_valid;
  logic                  fifo_push;
  logic [FW-1:0]         fifo_data_in_enable;
  logic                  fifo_full;
  logic                  fifo_flush;
  logic                  jump_valid;
  logic [31:0]           jump_pc;
  logic [31:0]           fetch_stall_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic        ready_en = 1'b1;
  int unsigned resp_lat = 1;

  fetch_stage #(
    .FETCH_WIDTH (FW),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus_req             (bus_req),
    .bus_addr            (bus_addr),
    .bus_ready           (bus_ready),
    .bus_rvalid          (bus_rvalid),
    .bus_rdata           (bus_rdata),
    .fifo_data_in        (fifo_data_in),
    .fifo_data_in_valid  (fifo_data_in_valid),
    .fifo_push           (fifo_push),
    .fifo_data_in_enable (fifo_data_in_enable),
    .fifo_full           (fifo_full),
    .fifo_flush          (fifo_flush),
    .jump_valid          (jump_valid),
    .jump_pc             (jump_pc),
    .fetch_stall_cnt     (fetch_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_push(input int budget, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      samp();
      if (fifo_push) got = 1'b1;
    end
    check(name, got, 1);
  endtask

  task automatic wait_req(input int budget, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      samp();
      if (bus_req) got = 1'b1;
    end
    check(name, got, 1);
  endtask

  // Bus responder: answers each accepted request after resp_lat cycles with
  // the block for the accepted address; forgets everything on reset.
  initial begin : responder
    logic        hs, pend;
    logic [31:0] hs_addr, p_addr;
    int unsigned cnt;
    pend       = 1'b0;
    p_addr     = '0;
    cnt        = 0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    forever begin
      @(negedge clk);
      hs      = !rst && bus_req && bus_ready;
      hs_addr = bus_addr;
      @(posedge clk);
      #2;
      bus_rvalid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (hs) begin
          pend   = 1'b1;
          p_addr = hs_addr;
          cnt    = resp_lat;
        end
        if (pend) begin
          if (cnt <= 1) begin
            bus_rvalid = 1'b1;
            for (int i = 0; i < FW; i++) bus_rdata[i*32 +: 32] = inst_of(p_addr + 32'(4 * i));
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
      bus_ready = ready_en;
    end
  end

  // Fetch model: the next push must carry the instructions from model_pc to
  // the end of its block; requests must target that block and never overlap.
  initial begin : compare
    logic [31:0]   model_pc;
    logic          outstanding;
    int unsigned   k, n;
    logic [FW-1:0] exp_valid;
    model_pc    = RESET_PC;
    outstanding = 1'b0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        model_pc    = RESET_PC;
        outstanding = 1'b0;
      end else begin
        check("m_flush", fifo_flush, jump_valid);
        if (bus_req) begin
          check("m_bus_addr", bus_addr, model_pc & ~32'(FW * 4 - 1));
          check("m_one_outstanding", outstanding, 0);
        end
        if (fifo_push) begin
          k = (model_pc >> 2) % FW;
          n = FW - k;
          exp_valid = '0;
          for (int i = 0; i < n; i++) exp_valid[i] = 1'b1;
          check("m_push_valid", fifo_data_in_valid, exp_valid);
          for (int i = 0; i < n; i++) begin
            check("m_lane_pc", fifo_data_in[i].pc, model_pc + 32'(4 * i));
            check("m_lane_inst", fifo_data_in[i].inst, inst_of(model_pc + 32'(4 * i)));
          end
          check("m_push_space", $countones(fifo_data_in_enable) >= n, 1);
          check("m_push_not_full", fifo_full, 0);
          check("m_push_no_jump", jump_valid, 0);
          model_pc = (model_pc & ~32'(FW * 4 - 1)) + 32'(FW * 4);
        end
        if (jump_valid) model_pc = jump_pc;
        if (bus_rvalid) outstanding = 1'b0;
        if (bus_req && bus_ready) outstanding = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst                 = 1'b1;
    jump_valid          = 1'b0;
    jump_pc             = '0;
    fifo_full           = 1'b0;
    fifo_data_in_enable = 2'b11;

    // Reset values
    repeat (2) samp();
    check("rst_bus_req", bus_req, 0);
    check("rst_push", fifo_push, 0);
    check("rst_flush", fifo_flush, 0);
    check("rst_valid", fifo_data_in_valid, 0);
    check("rst_stall", fetch_stall_cnt, 0);
    tick();
    rst = 1'b0;

    // First block: request, one-cycle response, push, next request
    samp();
    check("c0_bus_req", bus_req, 1);
    check("c0_bus_addr", bus_addr, 32'h8000_0000);
    tick(); samp();
    check("c1_wait_no_req", bus_req, 0);
    tick(); samp();
    check("c2_push", fifo_push, 1);
    check("c2_valid", fifo_data_in_valid, 2'b11);
    check("c2_lane0_pc", fifo_data_in[0].pc, 32'h8000_0000);
    check("c2_lane1_pc", fifo_data_in[1].pc, 32'h8000_0004);
    check("c2_lane0_inst", fifo_data_in[0].inst, inst_of(32'h8000_0000));
    tick();
    ready_en = 1'b0;
    samp();
    check("c3_bus_req", bus_req, 1);
    check("c3_bus_addr", bus_addr, 32'h8000_0008);

    // Redirect to an odd word in a block
    tick();
    jump_valid = 1'b1;
    jump_pc    = 32'h8000_0104;
    samp();
    check("j1_flush", fifo_flush, 1);
    check("j1_no_push", fifo_push, 0);
    tick();
    jump_valid = 1'b0;
    ready_en   = 1'b1;
    samp();
    check("j1_bus_req", bus_req, 1);
    check("j1_bus_addr", bus_addr, 32'h8000_0100);
    check("j1_flush_off", fifo_flush, 0);
    wait_push(10, "j1_push_seen");
    check("j1_valid", fifo_data_in_valid, 2'b01);
    check("j1_lane0_pc", fifo_data_in[0].pc, 32'h8000_0104);

    // Insufficient FIFO space: hold for five cycles
    tick();
    fifo_data_in_enable = 2'b01;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        samp();
        if (fifo_data_in_valid != '0) got = 1'b1;
      end
      check("st_hold_seen", got, 1);
    end
    check("st_h1_no_push", fifo_push, 0);
    for (int j = 2; j <= 5; j++) begin
      tick(); samp();
      check("st_no_push", fifo_push, 0);
      check("st_valid", fifo_data_in_valid, 2'b11);
      check("st_no_req", bus_req, 0);
    end
    tick();
    fifo_data_in_enable = 2'b11;
    samp();
    check("st_count", fetch_stall_cnt, EXP_STALL);
    check("st_push", fifo_push, 1);
    check("st_lane0_pc", fifo_data_in[0].pc, 32'h8000_0108);

    // Redirect while waiting on a slow response
    tick();
    resp_lat = 4;
    samp();
    check("w_bus_addr", bus_addr, 32'h8000_0110);
    tick(); samp();
    check("w_waiting", bus_req, 0);
    tick();
    jump_valid = 1'b1;
    jump_pc    = 32'h8000_0200;
    samp();
    check("w_flush", fifo_flush, 1);
    tick();
    jump_valid = 1'b0;
    samp();
    check("w_flush_one", fifo_flush, 0);
    check("w_drop_no_req1", bus_req, 0);
    tick(); samp();
    check("w_stale_back", bus_rvalid, 1);
    check("w_drop_no_req2", bus_req, 0);
    tick();
    resp_lat = 1;
    samp();
    check("w_req_after", bus_req, 1);
    check("w_addr_after", bus_addr, 32'h8000_0200);
    wait_push(10, "w_push_seen");
    check("w_lane0_pc", fifo_data_in[0].pc, 32'h8000_0200);

    // Redirect while a request is being accepted; address wrap
    tick();
    jump_valid = 1'b1;
    jump_pc    = 32'hFFFF_FFF8;
    samp();
    check("r_flush", fifo_flush, 1);
    check("r_req_accepted", bus_req && bus_ready, 1);
    tick();
    jump_valid = 1'b0;
    samp();
    check("r_drop_no_req", bus_req, 0);
    wait_push(10, "r_push_seen");
    check("r_valid", fifo_data_in_valid, 2'b11);
    check("r_lane1_pc", fifo_data_in[1].pc, 32'hFFFF_FFFC);
    wait_req(5, "r_req_seen");
    check("r_wrap_addr", bus_addr, 32'h0000_0000);

    // Reset while holding a block
    tick();
    fifo_full = 1'b1;
    tick(); samp();
    check("h_valid", fifo_data_in_valid, 2'b11);
    check("h_no_push_full", fifo_push, 0);
    check("h_stall_sticky", fetch_stall_cnt, EXP_STALL);
    #1 rst = 1'b1;
    #1;
    check("h_rst_req", bus_req, 0);
    check("h_rst_push", fifo_push, 0);
    check("h_rst_flush", fifo_flush, 0);
    check("h_rst_valid", fifo_data_in_valid, 0);
    check("h_rst_stall", fetch_stall_cnt, 0);
    fifo_full = 1'b0;
    tick();
    rst = 1'b0;
    samp();
    check("h_req_after", bus_req, 1);
    check("h_addr_after", bus_addr, 32'h8000_0000);
    wait_push(10, "h_push_seen");
    check("h_lane0_pc", fifo_data_in[0].pc, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
